// File: rtl/date_counter.sv
// -----------------------------------------------------------------------------
// date_counter
//
// Calendar stage that sits directly after the hour/min/sec timer. It keeps
// day/month/year for the years 2000-2099 (year is held as an offset from
// 2000). The date advances once per rising edge of the timer's day-rollover
// level. It can also be stepped by three debounced buttons, or loaded as a
// whole from the serial port. Leap years and month lengths are handled here:
// day is clamped whenever a month or year change makes it out of range.
//
// Ports:
//   clk       in   1  system clock (same 1 kHz clock as the timer)
//   reset     in   1  asynchronous, active-high reset
//   oneday    in   1  day-rollover level from the timer (may stay high ~1 h)
//   bday      in   1  day-increment button (debounced level)
//   bmonth    in   1  month-increment button (debounced level)
//   byear     in   1  year-increment button (debounced level)
//   serialen  in   1  serial load enable (level, evaluated every cycle)
//   syear     in   7  serial year offset, 0-99
//   smonth    in   4  serial month, 1-12
//   sday      in   5  serial day, 1-31
//   year      out  7  year offset from 2000, 0-99
//   month     out  4  month, 1-12
//   day       out  5  day of month, 1-31
//   newyear   out  1  one-cycle pulse on a Dec 31 -> Jan 1 calendar advance
//   load_err  out  1  one-cycle pulse when a serial load is rejected
// -----------------------------------------------------------------------------
module date_counter #(
    parameter int RST_YEAR  = 14,
    parameter int RST_MONTH = 1,
    parameter int RST_DAY   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       oneday,
    input  logic       bday,
    input  logic       bmonth,
    input  logic       byear,
    input  logic       serialen,
    input  logic [6:0] syear,
    input  logic [3:0] smonth,
    input  logic [4:0] sday,
    output logic [6:0] year,
    output logic [3:0] month,
    output logic [4:0] day,
    output logic       newyear,
    output logic       load_err
);

    localparam logic [6:0] RST_YEAR_V  = 7'(RST_YEAR);
    localparam logic [3:0] RST_MONTH_V = 4'(RST_MONTH);
    localparam logic [4:0] RST_DAY_V   = 5'(RST_DAY);

    // ------------------------------------------------------------------
    // Calendar helpers
    // ------------------------------------------------------------------

    // Within 2000-2099 the simple divisible-by-4 rule is exact (2000 is leap).
    function automatic logic is_leap(input logic [6:0] y);
        return (y[1:0] == 2'd0);
    endfunction

    // Number of days in month m of year offset y. Out-of-range months map to
    // 31 so that the function is total; callers never rely on that value for
    // a committed date.
    function automatic logic [4:0] days_in_month(input logic [3:0] m,
                                                 input logic [6:0] y);
        logic [4:0] d;
        case (m)
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: d = 5'd31;
            4'd4, 4'd6, 4'd9, 4'd11:                    d = 5'd30;
            4'd2:    d = is_leap(y) ? 5'd29 : 5'd28;
            default: d = 5'd31;
        endcase
        return d;
    endfunction

    // Pull a day back into range after the month or year has changed.
    function automatic logic [4:0] clamp_day(input logic [4:0] d,
                                             input logic [4:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Year offset wraps 99 -> 0 (2099 -> 2000).
    function automatic logic [6:0] inc_year(input logic [6:0] y);
        return (y >= 7'd99) ? 7'd0 : (y + 7'd1);
    endfunction

    // A serial date is accepted only if every field is in range for the
    // month and year it names.
    function automatic logic serial_valid(input logic [6:0] y,
                                          input logic [3:0] m,
                                          input logic [4:0] d);
        logic ok;
        ok = (m >= 4'd1) && (m <= 4'd12) && (y <= 7'd99) &&
             (d >= 5'd1) && (d <= days_in_month(m, y));
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic oneday_d_r;
    logic btn_d_r;
    logic btn_any_s;
    logic day_tick_s;
    logic bday_press_s;
    logic bmonth_press_s;
    logic byear_press_s;

    // One shared history bit for all three buttons: while any button is held,
    // a press of another one is not seen as a new edge.
    assign btn_any_s      = bday | bmonth | byear;
    assign day_tick_s     = oneday & ~oneday_d_r;
    assign bday_press_s   = bday   & ~btn_d_r;
    assign bmonth_press_s = bmonth & ~btn_d_r;
    assign byear_press_s  = byear  & ~btn_d_r;

    // ------------------------------------------------------------------
    // Next-state computation
    // ------------------------------------------------------------------
    logic [4:0] dim_cur_s;
    logic [3:0] month_inc_s;
    logic [6:0] year_inc_s;
    logic       load_ok_s;

    logic [6:0] year_n_s;
    logic [3:0] month_n_s;
    logic [4:0] day_n_s;
    logic       newyear_n_s;
    logic       load_err_n_s;

    assign dim_cur_s   = days_in_month(month, year);
    assign month_inc_s = (month >= 4'd12) ? 4'd1 : (month + 4'd1);
    assign year_inc_s  = inc_year(year);
    assign load_ok_s   = serial_valid(syear, smonth, sday);

    // Select exactly one action per cycle; lower-priority events that
    // coincide with a higher one are dropped.
    always_comb begin
        year_n_s     = year;
        month_n_s    = month;
        day_n_s      = day;
        newyear_n_s  = 1'b0;
        load_err_n_s = 1'b0;

        if (day_tick_s) begin
            // Calendar advance with full carry into month and year.
            if (day < dim_cur_s) begin
                day_n_s = day + 5'd1;
            end else begin
                day_n_s = 5'd1;
                if (month < 4'd12) begin
                    month_n_s = month + 4'd1;
                end else begin
                    month_n_s   = 4'd1;
                    year_n_s    = year_inc_s;
                    newyear_n_s = 1'b1;
                end
            end
        end else if (bday_press_s) begin
            // Day button wraps within the month; no carry.
            day_n_s = (day >= dim_cur_s) ? 5'd1 : (day + 5'd1);
        end else if (bmonth_press_s) begin
            // Month button wraps 12 -> 1 without touching the year.
            month_n_s = month_inc_s;
            day_n_s   = clamp_day(day, days_in_month(month_inc_s, year));
        end else if (byear_press_s) begin
            // Year button can move Feb 29 into a non-leap year.
            year_n_s = year_inc_s;
            day_n_s  = clamp_day(day, days_in_month(month, year_inc_s));
        end else if (serialen) begin
            if (load_ok_s) begin
                year_n_s  = syear;
                month_n_s = smonth;
                day_n_s   = sday;
            end else begin
                load_err_n_s = 1'b1;
            end
        end else begin
            year_n_s  = year;
            month_n_s = month;
            day_n_s   = day;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------

    // Edge history resets high so that a level already high at reset
    // release does not count as an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            oneday_d_r <= 1'b1;
            btn_d_r    <= 1'b1;
        end else begin
            oneday_d_r <= oneday;
            btn_d_r    <= btn_any_s;
        end
    end

    // Date registers and one-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            year     <= RST_YEAR_V;
            month    <= RST_MONTH_V;
            day      <= RST_DAY_V;
            newyear  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            year     <= year_n_s;
            month    <= month_n_s;
            day      <= day_n_s;
            newyear  <= newyear_n_s;
            load_err <= load_err_n_s;
        end
    end

endmodule

// File: tb/tb_date_counter.sv
// -----------------------------------------------------------------------------
// tb_date_counter
//
// Self-checking bench for date_counter. Each scenario task builds a small
// stimulus table. Every row drives the inputs for one clock cycle and pushes
// the date expected after that edge onto a scoreboard queue. The expected
// entry is popped and compared once the edge has happened.
// Expected word layout: {year[6:0], month[3:0], day[4:0], newyear, load_err}.
// -----------------------------------------------------------------------------
module tb_date_counter;

    logic       clk;
    logic       reset;
    logic       oneday;
    logic       bday;
    logic       bmonth;
    logic       byear;
    logic       serialen;
    logic [6:0] syear;
    logic [3:0] smonth;
    logic [4:0] sday;
    logic [6:0] year;
    logic [3:0] month;
    logic [4:0] day;
    logic       newyear;
    logic       load_err;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [17:0] sb_q[$];

    typedef struct {
        logic        od, bd, bm, by, se;
        logic [6:0]  sy;
        logic [3:0]  sm;
        logic [4:0]  sd;
        logic [17:0] exp;
    } step_t;

    date_counter #(.RST_YEAR(14), .RST_MONTH(1), .RST_DAY(1)) dut (
        .clk(clk), .reset(reset), .oneday(oneday), .bday(bday),
        .bmonth(bmonth), .byear(byear), .serialen(serialen),
        .syear(syear), .smonth(smonth), .sday(sday),
        .year(year), .month(month), .day(day),
        .newyear(newyear), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] pack(input int y, input int m, input int d,
                                         input int ny, input int le);
        return {7'(y), 4'(m), 5'(d), 1'(ny), 1'(le)};
    endfunction

    // Row: inputs (oneday, bday, bmonth, byear, serialen, syear, smonth, sday)
    // followed by the expected date/pulses after the clock edge.
    function automatic step_t mk(input int od, input int bd, input int bm,
                                 input int by, input int se, input int sy,
                                 input int sm, input int sd, input int ey,
                                 input int em, input int ed, input int eny,
                                 input int ele);
        step_t s;
        s.od  = 1'(od);
        s.bd  = 1'(bd);
        s.bm  = 1'(bm);
        s.by  = 1'(by);
        s.se  = 1'(se);
        s.sy  = 7'(sy);
        s.sm  = 4'(sm);
        s.sd  = 5'(sd);
        s.exp = pack(ey, em, ed, eny, ele);
        return s;
    endfunction

    task automatic drive_step(input step_t s);
        oneday   = s.od;
        bday     = s.bd;
        bmonth   = s.bm;
        byear    = s.by;
        serialen = s.se;
        syear    = s.sy;
        smonth   = s.sm;
        sday     = s.sd;
        sb_q.push_back(s.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t tab[$];
        logic [17:0] got, exp;
        reset = 1'b1; oneday = 1'b1; bday = 1'b0; bmonth = 1'b0; byear = 1'b0;
        serialen = 1'b0; syear = 7'd0; smonth = 4'd0; sday = 5'd0;
        sb_q.push_back(pack(14, 1, 1, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        got = {year, month, day, newyear, load_err};
        exp = sb_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL reset_value: got %0d-%0d-%0d ny=%0b le=%0b, expected %0d-%0d-%0d ny=%0b le=%0b",
                     got[17:11], got[10:7], got[6:2], got[1], got[0],
                     exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
        end
        reset = 1'b0;
        // oneday already high at release: no advance however long it stays.
        for (int i = 0; i < 100; i++) tab.push_back(mk(1,0,0,0,0, 0,0,0, 14,1,1,0,0));
        foreach (tab[i]) begin
            drive_step(tab[i]);
            got = {year, month, day, newyear, load_err};
            exp = sb_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got %0d-%0d-%0d ny=%0b le=%0b, expected %0d-%0d-%0d ny=%0b le=%0b",
                         i, got[17:11], got[10:7], got[6:2], got[1], got[0],
                         exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_day_tick();
        step_t tab[$];
        logic [17:0] got, exp;
        tab.push_back(mk(0,0,0,0,1, 15,2,28, 15,2,28,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,   15,3,1,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,   15,3,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 16,2,28, 16,2,28,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,   16,2,29,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   16,2,29,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,   16,3,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 15,4,30, 15,4,30,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,   15,5,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 15,7,9,  15,7,9,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,   15,7,10,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   15,7,10,0,0));
        foreach (tab[i]) begin
            drive_step(tab[i]);
            got = {year, month, day, newyear, load_err};
            exp = sb_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL day_tick[%0d]: got %0d-%0d-%0d ny=%0b le=%0b, expected %0d-%0d-%0d ny=%0b le=%0b",
                         i, got[17:11], got[10:7], got[6:2], got[1], got[0],
                         exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_newyear();
        step_t tab[$];
        logic [17:0] got, exp;
        tab.push_back(mk(0,0,0,0,1, 99,12,31, 99,12,31,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,    0,1,1,1,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,    0,1,1,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,    0,1,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 20,12,31, 20,12,31,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0,    21,1,1,1,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,    21,1,1,0,0));
        foreach (tab[i]) begin
            drive_step(tab[i]);
            got = {year, month, day, newyear, load_err};
            exp = sb_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL newyear[%0d]: got %0d-%0d-%0d ny=%0b le=%0b, expected %0d-%0d-%0d ny=%0b le=%0b",
                         i, got[17:11], got[10:7], got[6:2], got[1], got[0],
                         exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_buttons();
        step_t tab[$];
        logic [17:0] got, exp;
        tab.push_back(mk(0,0,0,0,1, 16,1,31, 16,1,31,0,0));
        tab.push_back(mk(0,0,1,0,0, 0,0,0,   16,2,29,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   16,2,29,0,0));
        tab.push_back(mk(0,0,0,1,0, 0,0,0,   17,2,28,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   17,2,28,0,0));
        tab.push_back(mk(0,1,0,0,0, 0,0,0,   17,2,1,0,0));
        tab.push_back(mk(0,1,0,0,0, 0,0,0,   17,2,1,0,0));
        tab.push_back(mk(0,1,1,0,0, 0,0,0,   17,2,1,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   17,2,1,0,0));
        tab.push_back(mk(0,0,1,0,0, 0,0,0,   17,3,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 99,3,1,  99,3,1,0,0));
        tab.push_back(mk(0,0,0,1,0, 0,0,0,   0,3,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 5,12,15, 5,12,15,0,0));
        tab.push_back(mk(0,0,1,0,0, 0,0,0,   5,1,15,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   5,1,15,0,0));
        tab.push_back(mk(0,1,0,0,0, 0,0,0,   5,1,16,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   5,1,16,0,0));
        foreach (tab[i]) begin
            drive_step(tab[i]);
            got = {year, month, day, newyear, load_err};
            exp = sb_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL buttons[%0d]: got %0d-%0d-%0d ny=%0b le=%0b, expected %0d-%0d-%0d ny=%0b le=%0b",
                         i, got[17:11], got[10:7], got[6:2], got[1], got[0],
                         exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_serial();
        step_t tab[$];
        logic [17:0] got, exp;
        tab.push_back(mk(0,0,0,0,1, 20,1,1,   20,1,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 20,2,30,  20,1,1,0,1));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,    20,1,1,0,0));
        tab.push_back(mk(0,0,0,0,1, 20,2,29,  20,2,29,0,0));
        tab.push_back(mk(0,0,0,0,1, 20,2,29,  20,2,29,0,0));
        tab.push_back(mk(0,0,0,0,1, 20,13,1,  20,2,29,0,1));
        tab.push_back(mk(0,0,0,0,1, 20,0,1,   20,2,29,0,1));
        tab.push_back(mk(0,0,0,0,1, 20,2,0,   20,2,29,0,1));
        tab.push_back(mk(0,0,0,0,1, 100,1,1,  20,2,29,0,1));
        tab.push_back(mk(0,0,0,0,1, 21,2,29,  20,2,29,0,1));
        tab.push_back(mk(0,0,0,0,1, 21,4,31,  20,2,29,0,1));
        tab.push_back(mk(0,0,0,0,1, 21,4,30,  21,4,30,0,0));
        tab.push_back(mk(0,0,0,0,1, 99,12,31, 99,12,31,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,    99,12,31,0,0));
        // A button press wins over a same-cycle serial load.
        tab.push_back(mk(0,0,0,0,1, 21,4,30,  21,4,30,0,0));
        tab.push_back(mk(0,1,0,0,1, 30,6,6,   21,4,1,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,    21,4,1,0,0));
        foreach (tab[i]) begin
            drive_step(tab[i]);
            got = {year, month, day, newyear, load_err};
            exp = sb_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL serial[%0d]: got %0d-%0d-%0d ny=%0b le=%0b, expected %0d-%0d-%0d ny=%0b le=%0b",
                         i, got[17:11], got[10:7], got[6:2], got[1], got[0],
                         exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_priority();
        step_t tab[$];
        logic [17:0] got, exp;
        tab.push_back(mk(0,0,0,0,1, 14,5,10, 14,5,10,0,0));
        tab.push_back(mk(1,1,0,0,0, 0,0,0,   14,5,11,0,0));
        tab.push_back(mk(0,1,0,0,0, 0,0,0,   14,5,11,0,0));
        tab.push_back(mk(0,1,0,0,0, 0,0,0,   14,5,11,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   14,5,11,0,0));
        tab.push_back(mk(0,1,0,0,0, 0,0,0,   14,5,12,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   14,5,12,0,0));
        tab.push_back(mk(0,1,1,0,0, 0,0,0,   14,5,13,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   14,5,13,0,0));
        tab.push_back(mk(0,0,1,1,0, 0,0,0,   14,6,13,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   14,6,13,0,0));
        tab.push_back(mk(1,0,1,0,0, 0,0,0,   14,6,14,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0,   14,6,14,0,0));
        foreach (tab[i]) begin
            drive_step(tab[i]);
            got = {year, month, day, newyear, load_err};
            exp = sb_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL priority[%0d]: got %0d-%0d-%0d ny=%0b le=%0b, expected %0d-%0d-%0d ny=%0b le=%0b",
                         i, got[17:11], got[10:7], got[6:2], got[1], got[0],
                         exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_reset_midop();
        step_t tab[$];
        logic [17:0] got, exp;
        tab.push_back(mk(0,0,0,0,1, 50,7,7, 50,7,7,0,0));
        drive_step(tab[0]);
        got = {year, month, day, newyear, load_err};
        exp = sb_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL midop_load: got %0d-%0d-%0d ny=%0b le=%0b, expected %0d-%0d-%0d ny=%0b le=%0b",
                     got[17:11], got[10:7], got[6:2], got[1], got[0],
                     exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
        end
        // Asynchronous reset between clock edges, with levels held high.
        serialen = 1'b0; oneday = 1'b1; bday = 1'b1;
        #1;
        reset = 1'b1;
        sb_q.push_back(pack(14, 1, 1, 0, 0));
        #1;
        got = {year, month, day, newyear, load_err};
        exp = sb_q.pop_front();
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL midop_reset: got %0d-%0d-%0d ny=%0b le=%0b, expected %0d-%0d-%0d ny=%0b le=%0b",
                     got[17:11], got[10:7], got[6:2], got[1], got[0],
                     exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tab.delete();
        // Levels high across release are not edges.
        tab.push_back(mk(1,1,0,0,0, 0,0,0, 14,1,1,0,0));
        tab.push_back(mk(1,1,0,0,0, 0,0,0, 14,1,1,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 14,1,1,0,0));
        tab.push_back(mk(1,0,0,0,0, 0,0,0, 14,1,2,0,0));
        tab.push_back(mk(0,0,0,0,0, 0,0,0, 14,1,2,0,0));
        foreach (tab[i]) begin
            drive_step(tab[i]);
            got = {year, month, day, newyear, load_err};
            exp = sb_q.pop_front();
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL midop_release[%0d]: got %0d-%0d-%0d ny=%0b le=%0b, expected %0d-%0d-%0d ny=%0b le=%0b",
                         i, got[17:11], got[10:7], got[6:2], got[1], got[0],
                         exp[17:11], exp[10:7], exp[6:2], exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_day_tick();
        test_newyear();
        test_buttons();
        test_serial();
        test_priority();
        test_reset_midop();
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/date_counter.md
Name: date_counter

Overview:
- Calendar stage directly downstream of the hour/min/sec timer.
- Consumes the timer's day-rollover level `oneday` and maintains day/month/year for years 2000-2099.
- Supports button increments, a serial-port date load, leap years, and month-length clamping.
- Outputs feed the display multiplexer alongside hour/min/sec.

Parameters:
- RST_YEAR, 14: year offset from 2000 loaded at reset (0-99).
- RST_MONTH, 1: month loaded at reset (1-12).
- RST_DAY, 1: day loaded at reset (1-31, must be valid for RST_MONTH/RST_YEAR).

Ports:
- clk  in  1  system clock, same 1 kHz clock as the timer.
- reset  in  1  asynchronous, active-high reset.
- oneday  in  1  day-rollover level from the timer. Rises at 23:59:59->00:00:00 and stays high for up to an hour.
- bday  in  1  day-increment button (level, already debounced).
- bmonth  in  1  month-increment button.
- byear  in  1  year-increment button.
- serialen  in  1  serial load enable (level).
- syear  in  7  serial year, 0-99.
- smonth  in  4  serial month, 1-12.
- sday  in  5  serial day, 1-31.
- year  out  7  year offset from 2000, 0-99.
- month  out  4  1-12.
- day  out  5  1-31.
- newyear  out  1  one-cycle pulse on calendar Dec 31 -> Jan 1 advance.
- load_err  out  1  one-cycle pulse when a serial load is rejected.

Behaviour:
- Reset (async, reset=1):
  - year=RST_YEAR, month=RST_MONTH, day=RST_DAY, newyear=0, load_err=0.
  - Internal oneday_d=1, btn_d=1, so a level already high at release is not an edge.
- Edge detect, registered every clk:
  - btn_d = bday|bmonth|byear.
  - Press event = bX & ~btn_d. Holding any button blocks new presses of the others.
  - Day tick = oneday & ~oneday_d. Exactly one advance per oneday rising edge, regardless of its high duration.
- dim(m,y) = days in month. 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; for February, 29 if y[1:0]==0, else 28. Year 0 (2000) is leap.
- Per-cycle priority, exactly one action per cycle:
  1. day tick
  2. bday press
  3. bmonth press
  4. byear press
  5. serialen load
  6. hold
  - A lower-priority event coinciding with a higher one is dropped, not queued.
- Day tick:
  - If day<dim: day+1.
  - Else day=1. Then if month<12: month+1; else month=1, year=(year==99)?0:year+1, newyear=1 for that cycle.
- bday press: day=(day==dim)?1:day+1. Month and year are unchanged, no carry.
- bmonth press: month=(month==12)?1:month+1, no year carry. Then day=min(day, dim(new month, year)).
- byear press: year=(year==99)?0:year+1. Then day=min(day, dim(month, new year)), e.g. Feb 29 -> Feb 28.
- serialen load:
  - Valid when smonth in 1..12, syear<=99, and sday in 1..dim(smonth,syear).
  - Valid: load all three fields in the same cycle.
  - Invalid: no field changes and load_err=1 for that cycle.
  - Evaluated every cycle serialen is high, so a held valid value reloads repeatedly.
- All updates register on posedge clk; outputs change 1 cycle after the triggering input sample.
- newyear and load_err are 0 in all other cycles.
- Reset mid-operation returns immediately to the reset values. Pending edges are discarded.

Test Plan:
- Reset with oneday=1 held, release, hold oneday=1 for 100 cycles -> date stays RST values (2014-01-01), no advance.
- Start 2015-02-28, pulse oneday 0->1 -> 2015-03-01. From 2016-02-28 -> 2016-02-29, next edge -> 2016-03-01.
- Start 2099-12-31, oneday edge -> 2000-01-01 (year=0, month=1, day=1), newyear high exactly 1 cycle.
- Set 2016-01-31, press bmonth -> 2016-02-29. Press byear -> 2017-02-28. Press bday -> 2017-02-01 (wrap, month unchanged).
- serialen with syear=20, smonth=2, sday=30 -> no change, load_err 1-cycle pulse. syear=20, smonth=2, sday=29 -> date 2020-02-29, load_err=0.
- oneday edge and bday press in the same cycle from 2014-05-10 -> 2014-05-11 only; bday held afterwards gives no further increment until released and re-pressed.
